// File: rtl/lsu_seq.sv
// rtl/lsu_seq.sv - sequential load/store unit with a request/acknowledge memory port and timeout
// IDLE accepts one instruction, REQ holds the memory request, RESP reports completion for one cycle.
module lsu_seq #(
   parameter int DATA_W     = 8,
   parameter int REG_COUNT  = 4,
   parameter int ADDR_W     = 11,
   parameter int MEM_ADDR_W = 16,
   parameter int INSTR_W    = 16,
   parameter int TIMEOUT    = 15,
   parameter int REG_SEL_W  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [INSTR_W-1:0]    instruction,
   output logic [REG_SEL_W-1:0]  reg_raddr,
   input  logic [DATA_W-1:0]     reg_rdata,
   output logic                  reg_we,
   output logic [REG_SEL_W-1:0]  reg_waddr,
   output logic [DATA_W-1:0]     reg_wdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] CLASS_LSU = 2'b01;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic                  reg_we_q, reg_we_d;
   logic [REG_SEL_W-1:0]  reg_waddr_q, reg_waddr_d;
   logic [DATA_W-1:0]     reg_wdata_q, reg_wdata_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic [1:0]            instr_class;
   logic                  instr_store;
   logic [REG_SEL_W-1:0]  instr_reg;
   logic [ADDR_W-1:0]     instr_addr;

   assign instr_class = instruction[INSTR_W-1 -: 2];
   assign instr_store = instruction[INSTR_W-3];
   assign instr_reg   = instruction[ADDR_W +: REG_SEL_W];
   assign instr_addr  = instruction[ADDR_W-1:0];

   assign reg_raddr   = instr_reg;
   assign instr_ready = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      reg_waddr_d = reg_waddr_q;
      reg_wdata_d = reg_wdata_q;
      reg_we_d    = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Non-LSU classes are consumed silently; only class 01 starts a request.
            if (instr_valid && instr_class == CLASS_LSU) begin
               state_d     = ST_REQ;
               cnt_d       = '0;
               mem_en_d    = 1'b1;
               mem_we_d    = instr_store;
               mem_addr_d  = MEM_ADDR_W'(instr_addr);
               reg_waddr_d = instr_reg;
               if (instr_store) begin
                  mem_wdata_d = reg_rdata;
               end
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + 1'b1;
            // An acknowledge on the final counted cycle still completes normally.
            if (mem_ready) begin
               state_d  = ST_RESP;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               done_d   = 1'b1;
               if (!mem_we_q) begin
                  reg_wdata_d = mem_rdata;
                  reg_we_d    = 1'b1;
               end
            end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
               state_d  = ST_IDLE;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               error_d  = 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         reg_we_q    <= 1'b0;
         reg_waddr_q <= '0;
         reg_wdata_q <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         reg_we_q    <= reg_we_d;
         reg_waddr_q <= reg_waddr_d;
         reg_wdata_q <= reg_wdata_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign reg_we    = reg_we_q;
   assign reg_waddr = reg_waddr_q;
   assign reg_wdata = reg_wdata_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_lsu_seq.sv
// tb/tb_lsu_seq.sv - scoreboard bench for lsu_seq
// Stimulus pushes expected completions; a negedge monitor pops and compares them.
module tb_lsu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instruction;
   logic [1:0]  reg_raddr;
   logic [7:0]  reg_rdata;
   logic        reg_we;
   logic [1:0]  reg_waddr;
   logic [7:0]  reg_wdata;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic        busy;
   logic        done;
   logic        error;

   logic        instr_valid2;
   logic        instr_ready2;
   logic [17:0] instruction2;
   logic [2:0]  reg_raddr2;
   logic [15:0] reg_rdata2;
   logic        reg_we2;
   logic [2:0]  reg_waddr2;
   logic [15:0] reg_wdata2;
   logic        mem_en2;
   logic        mem_we2;
   logic [19:0] mem_addr2;
   logic [15:0] mem_wdata2;
   logic [15:0] mem_rdata2;
   logic        mem_ready2;
   logic        busy2;
   logic        done2;
   logic        error2;

   logic [7:0]  regs [4];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       is_done;
      logic       we;
      logic [1:0] waddr;
      logic [7:0] wdata;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   assign reg_rdata  = regs[reg_raddr];
   assign reg_rdata2 = 16'h0000;

   lsu_seq u_dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
      .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
      .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .busy(busy), .done(done), .error(error)
   );

   lsu_seq #(
      .DATA_W(16), .REG_COUNT(8), .ADDR_W(12), .MEM_ADDR_W(20), .INSTR_W(18), .TIMEOUT(15)
   ) u_dut_wide (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instruction(instruction2),
      .reg_raddr(reg_raddr2), .reg_rdata(reg_rdata2),
      .reg_we(reg_we2), .reg_waddr(reg_waddr2), .reg_wdata(reg_wdata2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
      .busy(busy2), .done(done2), .error(error2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic is_done, input logic we, input logic [1:0] waddr,
                       input logic [7:0] wdata);
      exp_t e;
      e.is_done = is_done;
      e.we      = we;
      e.waddr   = waddr;
      e.wdata   = wdata;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (reg_we) chk("reg_we_only_with_done", {31'd0, done}, 32'd1);
         if (done || error) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_response", {30'd0, done, error}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("resp_done", {31'd0, done}, {31'd0, e.is_done});
               chk("resp_error", {31'd0, error}, {31'd0, ~e.is_done});
               chk("resp_reg_we", {31'd0, reg_we}, {31'd0, e.we});
               if (e.we) begin
                  chk("resp_reg_waddr", {30'd0, reg_waddr}, {30'd0, e.waddr});
                  chk("resp_reg_wdata", {24'd0, reg_wdata}, {24'd0, e.wdata});
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [15:0] ins);
      int n = 0;
      while (!instr_ready && n < 50) begin
         tick();
         n++;
      end
      chk("issue_ready_wait", {31'd0, instr_ready}, 32'd1);
      instr_valid = 1'b1;
      instruction = ins;
      tick();
      instr_valid = 1'b0;
   endtask

   // Counts mem_en cycles from the current (first REQ) cycle; acknowledges on cycle waits+1.
   task automatic run_req(input int waits, input logic [7:0] rd, input logic [7:0] exp_wd,
                          input bit is_store, output int en_cycles);
      en_cycles = 0;
      mem_ready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (!mem_en) break;
         en_cycles++;
         if (is_store) begin
            chk("store_wdata_stable", {24'd0, mem_wdata}, {24'd0, exp_wd});
            chk("store_we_stable", {31'd0, mem_we}, 32'd1);
         end
         if (en_cycles > waits) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
         end
         tick();
         mem_ready = 1'b0;
         mem_rdata = 8'h00;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int en;
      rst_n        = 1'b0;
      instr_valid  = 1'b0;
      instruction  = 16'h0000;
      mem_rdata    = 8'h00;
      mem_ready    = 1'b0;
      instr_valid2 = 1'b0;
      instruction2 = 18'h0;
      mem_rdata2   = 16'h0;
      mem_ready2   = 1'b0;
      regs[0] = 8'h10; regs[1] = 8'h21; regs[2] = 8'hA3; regs[3] = 8'h3C;
      tick();
      tick();

      chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      chk("rst_reg_wdata", {24'd0, reg_wdata}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Load r1 from 0x205, zero wait states
      push(1'b1, 1'b1, 2'd1, 8'h5C);
      issue(16'h4A05);
      chk("ld_mem_en", {31'd0, mem_en}, 32'd1);
      chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
      chk("ld_mem_addr", {16'd0, mem_addr}, 32'h0205);
      chk("ld_busy", {31'd0, busy}, 32'd1);
      chk("ld_instr_ready_req", {31'd0, instr_ready}, 32'd0);
      run_req(0, 8'h5C, 8'h00, 1'b0, en);
      chk("ld_en_cycles", en, 32'd1);
      chk("ld_instr_ready_resp", {31'd0, instr_ready}, 32'd0);
      tick();
      chk("ld_idle_ready", {31'd0, instr_ready}, 32'd1);
      chk("ld_idle_busy", {31'd0, busy}, 32'd0);

      // Store r2 (0xA3) to 0x010 with three wait states
      push(1'b1, 1'b0, 2'd2, 8'h00);
      issue(16'h7010);
      chk("st_mem_addr", {16'd0, mem_addr}, 32'h0010);
      run_req(3, 8'hFF, 8'hA3, 1'b1, en);
      chk("st_en_cycles", en, 32'd4);
      chk("st_mem_we_after", {31'd0, mem_we}, 32'd0);
      tick();

      // Timeout on a load
      push(1'b0, 1'b0, 2'd1, 8'h00);
      issue(16'h4A05);
      run_req(1000, 8'h77, 8'h00, 1'b0, en);
      chk("to_en_cycles", en, 32'd15);
      chk("to_error", {31'd0, error}, 32'd1);
      chk("to_instr_ready", {31'd0, instr_ready}, 32'd1);
      chk("to_reg_we", {31'd0, reg_we}, 32'd0);
      tick();
      chk("to_error_pulse", {31'd0, error}, 32'd0);

      // Non-LSU class is consumed with no action
      issue(16'h8123);
      chk("nonlsu_mem_en", {31'd0, mem_en}, 32'd0);
      chk("nonlsu_busy", {31'd0, busy}, 32'd0);
      tick();
      tick();
      chk("nonlsu_mem_en_later", {31'd0, mem_en}, 32'd0);
      chk("nonlsu_done", {31'd0, done}, 32'd0);

      // Back-pressure: valid held high across an in-flight op
      push(1'b1, 1'b1, 2'd1, 8'h11);
      push(1'b1, 1'b1, 2'd3, 8'h22);
      instr_valid = 1'b1;
      instruction = 16'h4A05;
      tick();
      instruction = 16'h5FFF;
      chk("bp_instr_ready_req", {31'd0, instr_ready}, 32'd0);
      run_req(1, 8'h11, 8'h00, 1'b0, en);
      chk("bp_en_cycles", en, 32'd2);
      chk("bp_instr_ready_resp", {31'd0, instr_ready}, 32'd0);
      tick();
      chk("bp_idle_ready", {31'd0, instr_ready}, 32'd1);
      chk("bp_idle_mem_en", {31'd0, mem_en}, 32'd0);
      tick();
      instr_valid = 1'b0;
      chk("bp_second_mem_en", {31'd0, mem_en}, 32'd1);
      chk("bp_second_addr", {16'd0, mem_addr}, 32'h07FF);
      run_req(0, 8'h22, 8'h00, 1'b0, en);
      tick();

      // Reset during REQ of a load
      issue(16'h4A05);
      tick();
      chk("rstop_mem_en_before", {31'd0, mem_en}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstop_mem_en_async", {31'd0, mem_en}, 32'd0);
      chk("rstop_done", {31'd0, done}, 32'd0);
      chk("rstop_reg_we", {31'd0, reg_we}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("rstop_ready", {31'd0, instr_ready}, 32'd1);
      push(1'b1, 1'b1, 2'd1, 8'h66);
      issue(16'h4A05);
      run_req(0, 8'h66, 8'h00, 1'b0, en);
      chk("rstop_new_en_cycles", en, 32'd1);
      tick();

      // Wide parameter set: load r7 from 0xFFF
      instruction2 = 18'h17FFF;
      #1;
      chk("wide_reg_raddr", {29'd0, reg_raddr2}, 32'd7);
      instr_valid2 = 1'b1;
      tick();
      instr_valid2 = 1'b0;
      chk("wide_mem_en", {31'd0, mem_en2}, 32'd1);
      chk("wide_mem_addr", {12'd0, mem_addr2}, 32'h00FFF);
      chk("wide_mem_we", {31'd0, mem_we2}, 32'd0);
      mem_ready2 = 1'b1;
      mem_rdata2 = 16'hBEEF;
      tick();
      mem_ready2 = 1'b0;
      chk("wide_done", {31'd0, done2}, 32'd1);
      chk("wide_reg_we", {31'd0, reg_we2}, 32'd1);
      chk("wide_reg_waddr", {29'd0, reg_waddr2}, 32'd7);
      chk("wide_reg_wdata", {16'd0, reg_wdata2}, 32'hBEEF);
      tick();
      chk("wide_done_pulse", {31'd0, done2}, 32'd0);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Clocked, parametrised load/store unit. It replaces the combinational tri-state LSU between the instruction decoder, the register file and data memory.
- Accepts one memory-class instruction at a time over a valid/ready handshake and holds a memory request until the memory acknowledges it.
- On a load, writes the memory data back into the selected register; on a store, sources the data from that register.
- Uses separate in/out data buses (no inout) and adds timeout/error reporting.

Parameters:
DATA_W, 8, register and memory data width
REG_COUNT, 4, number of architectural registers; REG_SEL_W = clog2(REG_COUNT)
ADDR_W, 11, address field width inside the instruction
MEM_ADDR_W, 16, memory address bus width; must be >= ADDR_W, address zero-extended
INSTR_W, 16, instruction width; must equal 3 + REG_SEL_W + ADDR_W
TIMEOUT, 15, max cycles waiting for mem_ready; 0 = wait forever

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  unit can accept an instruction
instruction  in  INSTR_W  [INSTR_W-1:INSTR_W-2] class (01 = LSU), [INSTR_W-3] 1 = store / 0 = load, next REG_SEL_W bits register index, low ADDR_W bits address
reg_raddr  out  REG_SEL_W  register file read index, combinational = instruction register field
reg_rdata  in  DATA_W  register file read data (combinational read)
reg_we  out  1  register write enable, one-cycle pulse
reg_waddr  out  REG_SEL_W  register write index
reg_wdata  out  DATA_W  register write data
mem_en  out  1  memory request
mem_we  out  1  1 = write request
mem_addr  out  MEM_ADDR_W  memory address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid when mem_ready=1
mem_ready  in  1  memory acknowledge for current request
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: operation completed
error  out  1  one-cycle pulse: operation aborted on timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - instr_ready=1; busy, done, error, reg_we and mem_en all 0.
  - mem_we=0; mem_addr, mem_wdata, reg_waddr, reg_wdata all 0; timeout counter 0.
  - Reset mid-request drops mem_en immediately; the in-flight op is discarded, with no reg write and no done.
- State machine states: IDLE, REQ, RESP. All outputs are registered except reg_raddr and instr_ready (instr_ready = state==IDLE).
- IDLE:
  - Accept on instr_valid & instr_ready.
  - Class != 01: instruction is consumed with no action and no done; stay IDLE.
  - Class 01: latch op, register index and address (zero-extended). For a store, capture reg_rdata into mem_wdata. Go to REQ.
- REQ:
  - mem_en=1, mem_we=op; address and data held stable for the whole request.
  - Counter increments each REQ cycle.
  - On mem_ready=1 sampled: drop mem_en next cycle and go to RESP. For a load, capture mem_rdata into reg_wdata.
  - mem_ready is ignored outside REQ.
- Timeout: TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0 → next cycle error=1, mem_en=0, go IDLE. No reg write, no done. mem_ready sampled on the same edge the counter reaches TIMEOUT wins (normal completion).
- RESP (exactly one cycle): done=1. For a load, reg_we=1 with the latched reg_waddr/reg_wdata. Go to IDLE; the next instruction can be accepted in the cycle after RESP.
- Latency: accept at edge N → mem_en high from N+1. With mem_ready=1 in the first REQ cycle, done at N+2. Minimum throughput is one op per 3 cycles.
- reg_we is only ever high in RESP for loads; stores never write registers.

Test Plan:
- Load: instr 0x4A05 (load, r1, addr 0x205), mem_ready=1 in first REQ cycle with mem_rdata=0x5C → mem_addr=0x0205, mem_we=0 for 1 cycle; next cycle reg_we=1, reg_waddr=1, reg_wdata=0x5C, done=1.
- Store with wait states: instr 0x7010 (store, r2, addr 0x010), reg_rdata=0xA3, mem_ready after 3 REQ cycles → mem_en/mem_we high for 4 cycles, mem_wdata=0xA3 stable throughout; done=1, reg_we=0.
- Timeout: TIMEOUT=15, load, mem_ready held 0 → mem_en high 15 cycles, then error=1 for one cycle, no reg_we, back to IDLE with instr_ready=1.
- Non-LSU and back-pressure: instr 0x8123 while IDLE → consumed with no mem_en and no done. instr_valid held high during REQ → instr_ready=0 and a second op is accepted only after RESP.
- Reset mid-op: assert rst_n=0 during REQ of a load → mem_en falls asynchronously, no done or reg_we. After release, a new load completes normally.
- Parameter sweep: DATA_W=16, REG_COUNT=8, ADDR_W=12, INSTR_W=18, MEM_ADDR_W=20 → load to r7 at addr 0xFFF gives mem_addr=0x00FFF and reg_waddr=7.
